// File: rtl/sw_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sw_arb_pkg
// Brief   : Shared widths, one-hot port constants, FSM state type and helpers
//           for the switch arbiter and the round-robin picker.
// Revision: 1.0 - initial release
// ============================================================================
package sw_arb_pkg;

   localparam int NPORT     = 6;
   localparam int PORT_W    = $clog2(NPORT);
   localparam int PORT_P1_W = NPORT;

   typedef logic [PORT_W-1:0]    port_t;
   typedef logic [PORT_P1_W-1:0] port_oh_t;

   localparam port_oh_t C_P0_OH = 6'h01;
   localparam port_oh_t C_P1_OH = 6'h02;
   localparam port_oh_t C_P2_OH = 6'h04;
   localparam port_oh_t C_P3_OH = 6'h08;
   localparam port_oh_t C_P4_OH = 6'h10;
   localparam port_oh_t C_P5_OH = 6'h20;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic port_t oh2idx(input port_oh_t oh);
      port_t idx;
      idx = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (oh[i]) idx = idx | port_t'(i);
      end
      return idx;
   endfunction

   function automatic port_t next_port(input port_t p);
      return (p == port_t'(NPORT - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sw_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker: first asserted request searching
//           from i_ptr upward modulo N, returned one-hot, plus any-request flag.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int N  = 6,
   parameter int PW = 3
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic          o_any
);

   logic [PW:0]   w_sum;
   logic [PW-1:0] w_idx;
   logic          w_found;

   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
         w_idx = w_sum[PW-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/sw_arb.sv
`default_nettype none
// ============================================================================
// Module  : sw_arb
// Brief   : Per-output switch arbiter: round-robin grant held head-to-tail,
//           pop strobe for the granted input buffer. Optional stall watchdog
//           enabled by defining SW_ARB_WDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module sw_arb
   import sw_arb_pkg::*;
#(
   parameter int WDOG_CYCLES = 255,
   parameter int WDOG_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NPORT-1:0] i_req,
   input  logic             i_ovalid,
   input  logic             i_otail,
   input  logic             i_ostall,
   output logic [NPORT-1:0] o_grant,
   output logic [NPORT-1:0] o_pop,
   output logic             o_busy,
   output logic             o_wdog_err
);

   state_e   r_state, w_state_nxt;
   port_oh_t r_grant, w_grant_nxt, w_win;
   port_t    r_ptr, w_ptr_nxt, w_pick_ptr;
   logic     w_any, w_xfer, w_release, w_wdog_fire;

   assign w_xfer     = (r_state == ST_BUSY) & i_ovalid & ~i_ostall;
   assign w_release  = (w_xfer & i_otail) | w_wdog_fire;
   // At a release the just-served port drops to lowest priority for the handover pick.
   assign w_pick_ptr = w_release ? next_port(oh2idx(r_grant)) : r_ptr;

   rr_pick #(
      .N  (NPORT),
      .PW (PORT_W)
   ) u_pick (
      .i_req (i_req),
      .i_ptr (w_pick_ptr),
      .o_gnt (w_win),
      .o_any (w_any)
   );

`ifdef SW_ARB_WDOG_EN
   logic [WDOG_W-1:0] r_wdog_cnt, w_wdog_cnt_nxt;
   logic              r_wdog_err;

   assign w_wdog_fire = (r_state == ST_BUSY) & ~w_xfer &
                        (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

   always_comb begin
      w_wdog_cnt_nxt = r_wdog_cnt + 1'b1;
      if (r_state == ST_IDLE || w_xfer || w_wdog_fire) w_wdog_cnt_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdog_cnt <= '0;
         r_wdog_err <= 1'b0;
      end else begin
         r_wdog_cnt <= w_wdog_cnt_nxt;
         r_wdog_err <= w_wdog_fire;
      end
   end

   assign o_wdog_err = r_wdog_err;
`else
   assign w_wdog_fire = 1'b0;
   assign o_wdog_err  = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ptr_nxt   = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_grant_nxt = w_win;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_release) begin
               w_ptr_nxt = w_pick_ptr;
               if (w_any) begin
                  w_grant_nxt = w_win;
               end else begin
                  w_grant_nxt = '0;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign o_grant = r_grant;
   assign o_pop   = r_grant & {NPORT{w_xfer}};
   assign o_busy  = (r_state == ST_BUSY);

endmodule
`default_nettype wire
